// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, flush (redirect squash) and bubble gating of the control bus.
module pipe_stage_reg #(
    parameter int DATA_W = 8,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // Main entry drives the outputs; skid entry catches the beat that arrives
    // while main is stalled (only ever used when SKID != 0).
    logic              main_vld_q, main_vld_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic              skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    logic accept;
    logic emit;

    assign accept = in_valid & in_ready;
    assign emit   = main_vld_q & out_ready;

    // Next-state for both entries; flush squashes everything, including a
    // beat accepted in the same cycle.
    always_comb begin
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (emit && skid_vld_q) begin
            // in_ready was low (skid full), so no accept can coincide here
            main_vld_d  = 1'b1;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_vld_d  = 1'b0;
        end else if (emit) begin
            main_vld_d = accept;
            if (accept) begin
                main_data_d = in_data;
                main_ctrl_d = in_ctrl;
            end
        end else if (accept) begin
            if (main_vld_q && (SKID != 0)) begin
                skid_vld_d  = 1'b1;
                skid_data_d = in_data;
                skid_ctrl_d = in_ctrl;
            end else begin
                main_vld_d  = 1'b1;
                main_data_d = in_data;
                main_ctrl_d = in_ctrl;
            end
        end
    end

    // Entry registers; reset clears payloads too so out_data reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_q  <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;
            // Registered ready: high exactly when the skid entry will be empty,
            // which breaks the out_ready -> in_ready timing path.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) in_ready_q <= 1'b0;
                else        in_ready_q <= ~skid_vld_d;
            end
            assign in_ready = in_ready_q;
        end else begin : g_noskid
            // Single register: accept whenever the held beat leaves this cycle.
            assign in_ready = rst_n & (out_ready | ~main_vld_q);
        end
    endgenerate

    assign out_valid = main_vld_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_vld_q ? main_ctrl_q : '0;
    assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 8: width of the payload bus (register values, ALU result, memory data, immediates).
REQ-002 Parameter CTRL_W, default 8: width of the control bus (write enables, selects); gated to zero on bubbles.
REQ-003 Parameter SKID, default 1: 1 gives a 2-entry skid buffer with registered in_ready; 0 gives a single register with combinational in_ready.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  stage can accept a beat this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 in_ctrl  input  CTRL_W  upstream control bits.
REQ-010 flush  input  1  squash all held beats (branch/jump redirect).
REQ-011 out_valid  output  1  downstream beat present.
REQ-012 out_ready  input  1  downstream accepts the beat this cycle.
REQ-013 out_data  output  DATA_W  payload of the oldest held beat.
REQ-014 out_ctrl  output  CTRL_W  control of the oldest held beat; all zero when out_valid=0.
REQ-015 occupancy  output  2  number of held beats (0..2; never exceeds 1 when SKID=0).

Function
REQ-016 Accept occurs when in_valid=1 and in_ready=1; emit occurs when out_valid=1 and out_ready=1; both evaluated at the same rising edge.
REQ-017 SKID=1: in_ready is a register output, equal to 1 exactly when the skid entry is empty; no combinational path from out_ready to in_ready.
REQ-018 SKID=1: an accept with the main entry empty, or with the main entry emitting, loads main; an accept with main full and not emitting loads skid.
REQ-019 SKID=1: on emit with skid full, skid moves to main in the same edge; strict FIFO order and no beat lost or duplicated.
REQ-020 SKID=0: in_ready = out_ready or not out_valid (combinational); an accept loads main, overwriting a beat emitted in the same edge.
REQ-021 Latency: an accepted beat into empty stage appears on out_* the following cycle (1-cycle latency); throughput 1 beat/cycle with out_ready held high.
REQ-022 out_data always reflects the main entry; out_ctrl = main ctrl when out_valid=1, else zero.
REQ-023 flush=1 clears both valid bits at the edge; any beat accepted in that cycle is discarded; flush overrides emit and accept; data registers need not change.
REQ-024 After flush, out_valid=0, occupancy=0 and (SKID=1) in_ready=1 in the next cycle.
REQ-025 occupancy increments on accept-without-emit, decrements on emit-without-accept, unchanged on both or neither; forced to 0 by flush.
REQ-026 in_data/in_ctrl are ignored when no accept occurs; held beats are stable while out_valid=1 and out_ready=0.

Reset
REQ-027 rst_n=0 asynchronously forces out_valid=0, out_ctrl=0, out_data=0, occupancy=0, skid entry empty and cleared.
REQ-028 During reset in_ready=0; in_ready rises in the first cycle after rst_n deasserts (SKID=1) and no beat is accepted while rst_n=0.
REQ-029 Reset asserted mid-transfer discards all held beats with no output glitch toward out_valid=1.

Verification
REQ-030 Pass-through: out_ready=1, in beats 0x11,0x22,0x33 on consecutive cycles -> same values on out_data cycles 1,2,3 later by one, out_valid continuous.
REQ-031 Backpressure: send 0xA1,0xA2 with out_ready=0 -> occupancy=2, in_ready=0; raise out_ready -> 0xA1 then 0xA2 emitted, in_ready=1 after first emit.
REQ-032 Bubble gating: in_ctrl=0xFF with in_valid=0 -> out_ctrl=0x00, out_valid=0.
REQ-033 Flush: occupancy=2 plus in_valid=1 (0x55) and flush=1 same cycle -> next cycle out_valid=0, occupancy=0, 0x55 never emitted.
REQ-034 Async reset: assert rst_n=0 between clock edges with occupancy=1 -> out_valid and out_ctrl drop to 0 immediately, before next clk edge.
REQ-035 SKID=0 build: out_ready=0 with occupancy=1 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 combinationally and new beat replaces emitted one.
